sample_player: RTL
==================

# sample_player

Playback sequencer that sits directly downstream of the audio sample memory (`memory` / `audio_memory`). It walks a contiguous address range at a programmable sample rate, issues reads to the synchronous memory, and captures each returned word. It then presents each word to the audio output stage over a valid/ready handshake. It supports single-shot and looped playback, immediate stop, and underrun detection.

## Interface
Parameters:
- `AddressWidth`, 10, memory address width; must match the memory instance.
- `DataWidth`, 16, sample width; must match the memory instance.
- `ClkDiv`, 1042, clock cycles per sample period (50 MHz → ~48 kHz); legal range 4 .. 2^16-1.
- `LastAddr`, 2^AddressWidth-1, final address played; the range is 0..LastAddr.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `start`  in  1  begin playback from address 0; ignored while `busy`.
- `stop`  in  1  abort playback; return to IDLE next edge.
- `loop`  in  1  sampled on each end-of-range; 1 = wrap to 0, 0 = finish.
- `read_addr`  out  AddressWidth  address to memory.
- `mem_data`  in  DataWidth  memory read data, valid one cycle after `read_addr`.
- `sample_out`  out  DataWidth  current sample to output stage.
- `sample_valid`  out  1  `sample_out` holds an unconsumed sample.
- `sample_ready`  in  1  output stage accepts when `sample_valid && sample_ready`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when single-shot playback completes.
- `underrun`  out  1  sticky; set when a sample tick arrives while a sample is still unaccepted; cleared on `start`.

## Operation
- States:
  - IDLE → FETCH on `start && !stop`.
  - FETCH drives `read_addr` = addr_cnt, then goes to LATCH.
  - LATCH registers `mem_data` into `sample_out`, then goes to PRESENT.
  - PRESENT holds `sample_valid` = 1 until handshake, then goes to WAIT.
  - WAIT holds until a tick is pending, then goes to FETCH.
- Tick counter:
  - Cleared on `start`.
  - Counts 0..ClkDiv-1 while `busy`.
  - Asserts an internal `tick` on the terminal count, then wraps.
  - A tick sets `tick_pending`; entering FETCH clears it.
- Ticks and FETCH:
  - The first FETCH after `start` is immediate and does not wait for a tick.
  - Later FETCHes occur only after a pending tick.
- Underrun:
  - A tick while in PRESENT (or while `tick_pending` is already set) sets `underrun`.
  - Playback continues; the next FETCH occurs on the handshake cycle's successor. Ticks do not accumulate beyond one.
- End of range, on handshake of the sample from `LastAddr`:
  - If `loop` = 1: addr_cnt wraps to 0 and the FSM goes to WAIT.
  - If `loop` = 0: the FSM goes to IDLE and `done` pulses for one cycle.
- Other handshakes increment addr_cnt by 1; the addition is modulo 2^AddressWidth.
- `stop` from any state:
  - Next edge goes to IDLE; `sample_valid` drops and the in-flight sample is discarded.
  - No `done` pulse; `underrun` is retained.
- `start` and `stop` in the same cycle: `stop` wins and the FSM stays or goes IDLE.
- Asynchronous reset (`reset` = 0), including mid-playback: IDLE, addr_cnt = 0, tick counter = 0, `tick_pending` = 0.
- Output values in reset/IDLE: `read_addr` = 0, `sample_out` = 0, `sample_valid` = 0, `busy` = 0, `done` = 0, `underrun` = 0.
- `sample_out` is stable while `sample_valid` is high. It keeps the last accepted value in WAIT and IDLE, except after reset, when it is 0.

## Timing
- `start` sampled at edge E0: FETCH at E1, LATCH at E2, `sample_valid` = 1 from E3.
- Start-to-first-sample latency is 3 cycles.
- FETCH-to-valid latency is 2 cycles for every sample.
- Handshake at edge Eh: `sample_valid` = 0 from Eh+1 (WAIT), unless a tick is pending, in which case FETCH occurs at Eh+1.
- Steady state: one sample per `ClkDiv` cycles. The output stage must accept within `ClkDiv`-3 cycles of valid to avoid underrun.
- `done` is asserted in the cycle after the final handshake; `busy` is 0 in that same cycle.
- All outputs are registered; there is no combinational path from `sample_ready` to any output.

## Structure
- Shared package `player_pkg`: the state enum (IDLE, FETCH, LATCH, PRESENT, WAIT) and default constants (`ClkDiv` default, 2-bit handshake encodings).
- Sub-module `sample_tick_gen`:
  - Ports: `clk`, `reset`, `clear`, `enable`, `tick`.
  - Parameterised by `ClkDiv`.
  - Contains the modulo counter only.
- Top level `sample_player`: FSM, address counter, output register, `tick_pending`, `underrun`.

## Test plan
- Reset: hold `reset` = 0 for 3 cycles, then release → all outputs 0; `start` at E0 gives `read_addr` = 0 at E1 and `sample_valid` = 1 at E3, with `sample_out` = mem[0].
- Single-shot: `ClkDiv` = 8, `LastAddr` = 3, `loop` = 0, `sample_ready` tied 1 → samples mem[0..3] accepted 8 cycles apart, one `done` pulse after mem[3], then `busy` = 0.
- Loop:
  - Same setup with `loop` = 1 → sequence 0,1,2,3,0,1 with no `done`.
  - Drop `loop` to 0 during the second pass → `done` after the next mem[3].
- Back-pressure: `sample_ready` = 0 for 20 cycles with `ClkDiv` = 8 → `sample_out` held constant, `underrun` = 1; after release the next FETCH occurs one cycle after the handshake.
- Stop: assert `stop` in PRESENT, then in LATCH, then `start` and `stop` together from IDLE → IDLE next edge, `sample_valid` = 0, no `done`, and no start in the simultaneous case.
- Mid-operation reset: assert `reset` = 0 asynchronously between edges during PRESENT → outputs 0 immediately; after release, a restart begins from address 0 with `underrun` = 0.

Source files
------------

// File: rtl/player_pkg.sv
// Shared types and defaults for the sample playback sequencer.
// State encoding and the valid/ready pair encoding used by the top level.
package player_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    PRESENT,
    WAIT
  } state_e;

  localparam int ClkDivDefault = 1042;

  // {valid, ready} as seen by the output stage
  typedef enum logic [1:0] {
    HS_NONE  = 2'b00,
    HS_RDY   = 2'b01,
    HS_STALL = 2'b10,
    HS_XFER  = 2'b11
  } hs_e;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-period modulo counter; tick marks the terminal count.
// Held at zero while cleared, counts only while enabled.
module sample_tick_gen
  import player_pkg::*;
#(
  parameter int ClkDiv = ClkDivDefault
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CntW = $clog2(ClkDiv);

  logic [CntW-1:0] cnt;

  assign tick = enable && (cnt == CntW'(ClkDiv - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sample_player.sv
// Playback sequencer: walks memory 0..LastAddr at the sample rate
// and hands each word to the output stage over valid/ready.
module sample_player
  import player_pkg::*;
#(
  parameter int AddressWidth = 10,
  parameter int DataWidth    = 16,
  parameter int ClkDiv       = ClkDivDefault,
  parameter int LastAddr     = 2 ** AddressWidth - 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    loop,
  output logic [AddressWidth-1:0] read_addr,
  input  logic [DataWidth-1:0]    mem_data,
  output logic [DataWidth-1:0]    sample_out,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    underrun
);

  localparam logic [AddressWidth-1:0] LastA =
    AddressWidth'(LastAddr);

  state_e                  state;
  logic [AddressWidth-1:0] addr_cnt;
  logic [DataWidth-1:0]    last_acc;
  logic                    tick;
  logic                    tick_pending;
  logic                    tick_due;
  logic                    at_last;
  hs_e                     hs;

  assign busy      = (state != IDLE);
  assign read_addr = addr_cnt;
  assign tick_due  = tick || tick_pending;
  assign at_last   = (addr_cnt == LastA);
  assign hs        = hs_e'({sample_valid, sample_ready});

  sample_tick_gen #(
    .ClkDiv(ClkDiv)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (!busy),
    .enable(busy),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      addr_cnt     <= '0;
      sample_out   <= '0;
      last_acc     <= '0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
      underrun     <= 1'b0;
      tick_pending <= 1'b0;
    end else begin
      done <= 1'b0;
      if (tick) tick_pending <= 1'b1;
      if (tick && (state == PRESENT || tick_pending))
        underrun <= 1'b1;

      if (stop) begin
        // unaccepted sample is dropped; show the last one taken
        state        <= IDLE;
        addr_cnt     <= '0;
        sample_valid <= 1'b0;
        sample_out   <= last_acc;
        tick_pending <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state        <= FETCH;
              addr_cnt     <= '0;
              underrun     <= 1'b0;
              tick_pending <= 1'b0;
            end
          end
          FETCH: begin
            state <= LATCH;
          end
          LATCH: begin
            sample_out   <= mem_data;
            sample_valid <= 1'b1;
            state        <= PRESENT;
          end
          PRESENT: begin
            if (hs == HS_XFER) begin
              sample_valid <= 1'b0;
              last_acc     <= sample_out;
              if (at_last && !loop) begin
                state        <= IDLE;
                done         <= 1'b1;
                addr_cnt     <= '0;
                tick_pending <= 1'b0;
              end else begin
                addr_cnt <= at_last ? '0 : addr_cnt + 1'b1;
                if (tick_due) begin
                  state        <= FETCH;
                  tick_pending <= 1'b0;
                end else begin
                  state <= WAIT;
                end
              end
            end
          end
          WAIT: begin
            if (tick_due) begin
              state        <= FETCH;
              tick_pending <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
